// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue slice.
// Holds the default data/register widths, the queued-result record
// and the hard-wired zero register address.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_lookup.sv
// Priority lookup of one register address across the queue entries.
// Valid entries sit contiguously starting at rd_ptr (oldest), so walking
// forward from rd_ptr and letting later matches override earlier ones
// leaves the youngest matching entry selected.
// Optional feature macro: WBQ_FWD_EN (when undefined only the pending
// flag is produced, data is tied to zero and no data mux exists).
module wbq_lookup
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic [AW-1:0]                addr,
  input  logic [DEPTH-1:0]             valid,
  input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
  input  logic [DEPTH-1:0][AW-1:0]     rds,
`ifdef WBQ_FWD_EN
  input  logic [DEPTH-1:0][XLEN-1:0]   datas,
`endif
  output logic                         hit,
  output logic [XLEN-1:0]              data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Oldest-to-youngest scan; the last match seen is the youngest one
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (valid[idx] && (rds[idx] == addr) && (addr != AW'(REG_ZERO))) begin
        hit = 1'b1;
`ifdef WBQ_FWD_EN
        data = datas[idx];
`endif
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Writeback queue: buffers late results and drains one per cycle onto
// the register file write port (WE3/A3/WD3) while that port is free.
// Two lookup ports let decode see registers that are still queued.
// Optional feature macro: WBQ_FWD_EN (forward queued data to decode;
// when undefined the lookups report a pending flag only).
module wb_write_queue
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int AW    = wb_pkg::REG_AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_rd,
  input  logic [XLEN-1:0]            in_data,
  input  logic                       drain_en,
  output logic                       WE3,
  output logic [AW-1:0]              A3,
  output logic [XLEN-1:0]            WD3,
  input  logic [AW-1:0]              lk_a1,
  input  logic [AW-1:0]              lk_a2,
  output logic                       lk_hit1,
  output logic                       lk_hit2,
  output logic [XLEN-1:0]            lk_data1,
  output logic [XLEN-1:0]            lk_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  import wb_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][AW-1:0]    rd_mem;
  logic [DEPTH-1:0][XLEN-1:0]  data_mem;
  logic                        do_enq;
  logic                        do_drain;

  // No pass-through: a full queue refuses input even while draining.
  // Results for x0 complete the handshake but are never stored.
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign do_enq   = in_valid && in_ready && (in_rd != AW'(REG_ZERO));
  assign do_drain = drain_en && !empty;

  assign WE3 = do_drain;
  assign A3  = do_drain ? rd_mem[rd_ptr]   : '0;
  assign WD3 = do_drain ? data_mem[rd_ptr] : '0;

  // Entry storage, pointers and occupancy; reset discards everything queued
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid    <= '0;
      rd_mem   <= '0;
      data_mem <= '0;
    end else begin
      if (do_enq) begin
        rd_mem[wr_ptr]   <= in_rd;
        data_mem[wr_ptr] <= in_data;
        valid[wr_ptr]    <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_drain) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (do_enq && !do_drain) begin
        count <= count + 1'b1;
      end else if (!do_enq && do_drain) begin
        count <= count - 1'b1;
      end
    end
  end

  wbq_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_lookup1 (
    .addr   (lk_a1),
    .valid  (valid),
    .rd_ptr (rd_ptr),
    .rds    (rd_mem),
`ifdef WBQ_FWD_EN
    .datas  (data_mem),
`endif
    .hit    (lk_hit1),
    .data   (lk_data1)
  );

  wbq_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_lookup2 (
    .addr   (lk_a2),
    .valid  (valid),
    .rd_ptr (rd_ptr),
    .rds    (rd_mem),
`ifdef WBQ_FWD_EN
    .datas  (data_mem),
`endif
    .hit    (lk_hit2),
    .data   (lk_data2)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios followed by
// random traffic, compared every cycle against a queue-based model.
module tb_wb_write_queue;

  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        drain_en;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  lk_a1;
  logic [4:0]  lk_a2;
  logic        lk_hit1;
  logic        lk_hit2;
  logic [31:0] lk_data1;
  logic [31:0] lk_data2;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  wb_entry_t q[$];
  int nAsserts = 0;
  int nFails   = 0;

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH), .XLEN(32), .AW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rd    (in_rd),
    .in_data  (in_data),
    .drain_en (drain_en),
    .WE3      (WE3),
    .A3       (A3),
    .WD3      (WD3),
    .lk_a1    (lk_a1),
    .lk_a2    (lk_a2),
    .lk_hit1  (lk_hit1),
    .lk_hit2  (lk_hit2),
    .lk_data1 (lk_data1),
    .lk_data2 (lk_data2),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Youngest queued value for an address; x0 never matches
  function automatic void modelLookup(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 5'd0) begin
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (!h && q[k].rd == a) begin
          h = 1'b1;
`ifdef WBQ_FWD_EN
          d = q[k].data;
`endif
        end
      end
    end
  endfunction

  task automatic checkModel();
    int          n;
    logic        drn;
    logic        h1, h2;
    logic [31:0] d1, d2;
    n   = q.size();
    drn = drain_en && (n > 0);
    modelLookup(lk_a1, h1, d1);
    modelLookup(lk_a2, h2, d2);
    checkOutput("count",    count,    64'(n));
    checkOutput("empty",    empty,    64'(n == 0));
    checkOutput("full",     full,     64'(n == DEPTH));
    checkOutput("in_ready", in_ready, 64'(n != DEPTH));
    checkOutput("WE3",      WE3,      64'(drn));
    checkOutput("A3",       A3,       drn ? 64'(q[0].rd)   : 64'd0);
    checkOutput("WD3",      WD3,      drn ? 64'(q[0].data) : 64'd0);
    checkOutput("lk_hit1",  lk_hit1,  64'(h1));
    checkOutput("lk_hit2",  lk_hit2,  64'(h2));
    checkOutput("lk_data1", lk_data1, 64'(d1));
    checkOutput("lk_data2", lk_data2, 64'(d2));
  endtask

  // One clock cycle: drive, check combinational view, clock, advance model
  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] d,
                               input logic de, input logic [4:0] a1, input logic [4:0] a2,
                               input logic r);
    wb_entry_t e;
    logic      drn;
    logic      acc;
    rst      = r;
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    drain_en = de;
    lk_a1    = a1;
    lk_a2    = a2;
    #1;
    checkModel();
    drn = de && (q.size() > 0);
    acc = v && (q.size() < DEPTH);
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc && rd != 5'd0) begin
        e.rd   = rd;
        e.data = d;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
    drain_en = 1'b0; lk_a1 = '0; lk_a2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q.delete();
    rst = 1'b0;
    #1;
    checkOutput("init_empty", empty, 64'd1);
    checkOutput("init_we3",   WE3,   64'd0);

    // Reset discards three queued entries
    applyStimulus(1, 5'd3, 32'h33, 0, 5'd3, 5'd4, 0);
    applyStimulus(1, 5'd4, 32'h44, 0, 5'd3, 5'd4, 0);
    applyStimulus(1, 5'd9, 32'h99, 0, 5'd3, 5'd9, 0);
    applyStimulus(0, 5'd0, 32'h0,  1, 5'd3, 5'd9, 1);
    rst = 1'b0; drain_en = 1'b1;
    #1;
    checkOutput("rst_count", count, 64'd0);
    checkOutput("rst_empty", empty, 64'd1);
    checkOutput("rst_we3",   WE3,   64'd0);
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd3, 5'd9, 0);
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd4, 5'd9, 0);

    // Back-to-back drain of two entries
    applyStimulus(1, 5'd5, 32'h5, 1, 5'd5, 5'd6, 0);
    applyStimulus(1, 5'd6, 32'h4, 1, 5'd5, 5'd6, 0);
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd5, 5'd6, 0);
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd5, 5'd6, 0);

    // Fill, hold a fifth request, then drain while full
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 5'(10 + i), 32'h100 + i, 0, 5'd11, 5'd13, 0);
    applyStimulus(1, 5'd20, 32'hABCD, 0, 5'd20, 5'd10, 0);
    applyStimulus(1, 5'd20, 32'hABCD, 0, 5'd20, 5'd10, 0);
    applyStimulus(1, 5'd20, 32'hABCD, 1, 5'd20, 5'd10, 0);
    applyStimulus(1, 5'd20, 32'hABCD, 1, 5'd20, 5'd11, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 5'd0, 32'h0, 1, 5'd20, 5'd12, 0);

    // Duplicate destination: youngest wins on lookup
    applyStimulus(1, 5'd7, 32'h11, 0, 5'd7, 5'd0, 0);
    applyStimulus(1, 5'd7, 32'h22, 0, 5'd7, 5'd0, 0);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd7, 5'd0, 0);
    checkOutput("dup_hit1", lk_hit1, 64'd1);
    checkOutput("dup_hit2", lk_hit2, 64'd0);
`ifdef WBQ_FWD_EN
    checkOutput("dup_data1", lk_data1, 64'h22);
`else
    checkOutput("dup_data1", lk_data1, 64'h0);
`endif
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd7, 5'd0, 0);
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd7, 5'd0, 0);

    // Writes to x0 are dropped
    applyStimulus(1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0, 0);
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 0);
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 0);

    // Random traffic with small register range to provoke matches
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 49) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
